// File: rtl/inst_rom_loader.sv
// Instruction ROM filled from a big-endian byte stream after reset, then read asynchronously by fetch.
// Optional trailing 8-bit checksum byte when LOADER_CHECKSUM_EN is defined.
module inst_rom_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  input  logic        start_i,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  output logic        core_rst_n_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM = 3'd5
`endif
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           r_count;
  logic [1:0]            r_bidx;
  logic [ADDR_WIDTH-1:0] r_widx;
  logic [23:0]           r_sr;
  logic                  r_done;
  logic                  r_err;
  logic [31:0]           r_mem [DEPTH];
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_sum;
`endif

  logic        w_xfer;
  logic [15:0] w_len;
  logic        w_we;
  logic        w_last;
  logic        w_unused;

  assign byte_ready_o = (r_state != S_DONE) && (r_state != S_ERR);
  assign w_xfer = byte_valid_i & byte_ready_o;
  assign w_len  = {r_count[15:8], byte_i};
  assign w_we   = w_xfer && (r_state == S_DATA) && (r_bidx == 2'd3);
  assign w_last = 32'(r_widx) == (32'(r_count) - 32'd1);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LEN_HI: if (w_xfer) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (w_xfer) begin
          if (w_len == 16'd0)
            w_next = S_TAIL;
          else if (32'(w_len) > DEPTH)
            w_next = S_ERR;
          else
            w_next = S_DATA;
        end
      end
      S_DATA: if (w_we && w_last) w_next = S_TAIL;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_xfer)
          w_next = (byte_i == r_sum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: if (start_i) w_next = S_LEN_HI;
      default: w_next = S_LEN_HI;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_LEN_HI;
      r_count <= '0;
      r_bidx  <= '0;
      r_widx  <= '0;
      r_sr    <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == S_DONE);
      r_err   <= (w_next == S_ERR);
      if (w_xfer && r_state == S_LEN_HI)
        r_count[15:8] <= byte_i;
      if (w_xfer && r_state == S_LEN_LO) begin
        r_count <= w_len;
        r_bidx  <= '0;
        r_widx  <= '0;
`ifdef LOADER_CHECKSUM_EN
        r_sum   <= '0;
`endif
      end
      if (w_xfer && r_state == S_DATA) begin
        r_bidx <= r_bidx + 2'd1;
        r_sr   <= {r_sr[15:0], byte_i};
`ifdef LOADER_CHECKSUM_EN
        r_sum  <= r_sum + byte_i;
`endif
        if (r_bidx == 2'd3)
          r_widx <= r_widx + ADDR_WIDTH'(1);
      end
    end
  end

  // Memory is deliberately not reset so words survive a mid-load reset.
  always_ff @(posedge Clk) begin
    if (w_we)
      r_mem[r_widx] <= {r_sr, byte_i};
  end

  assign rom_data_o = (rom_ce_i && r_state == S_DONE)
                    ? r_mem[rom_addr_i[ADDR_WIDTH+1:2]]
                    : 32'h0;

  assign core_rst_n_o = r_done;
  assign load_done_o  = r_done;
  assign load_err_o   = r_err;

  assign w_unused = ^{rom_addr_i[31:ADDR_WIDTH+2], rom_addr_i[1:0]};

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader (ADDR_WIDTH=4): directed corner sequences, read table, random loads.
// Follows LOADER_CHECKSUM_EN when defined for the build.
module tb_inst_rom_loader;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef logic [7:0]  bq_t [$];
  typedef logic [31:0] wq_t [$];

  typedef struct {
    logic [31:0] addr;
    logic        ce;
    logic [31:0] data;
  } rv_t;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic        byte_ready_o;
  logic        start_i = 1'b0;
  logic        rom_ce_i = 1'b0;
  logic [31:0] rom_addr_i = 32'h0;
  logic [31:0] rom_data_o;
  logic        core_rst_n_o;
  logic        load_done_o;
  logic        load_err_o;

  int n_checks = 0;
  int n_err = 0;

  logic [31:0] exp_mem [DEPTH];
  bit          known [DEPTH];

  inst_rom_loader #(.ADDR_WIDTH(AW)) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .byte_i(byte_i),
    .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o),
    .start_i(start_i),
    .rom_ce_i(rom_ce_i),
    .rom_addr_i(rom_addr_i),
    .rom_data_o(rom_data_o),
    .core_rst_n_o(core_rst_n_o),
    .load_done_o(load_done_o),
    .load_err_o(load_err_o)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    byte_i = b;
    byte_valid_i = 1'b1;
    tick();
    byte_valid_i = 1'b0;
  endtask

  task automatic send_q(input bq_t q, input int maxgap);
    foreach (q[i]) send(q[i], $urandom_range(maxgap, 0));
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // {ready, core_rst_n, done, err}; ready is high exactly when neither done nor err
  task automatic status(input string name, input bit done, input bit err);
    chk(name, {28'h0, byte_ready_o, core_rst_n_o, load_done_o, load_err_o},
        {28'h0, !(done || err), done, done, err});
  endtask

  task automatic rd(input string name, input logic [31:0] a,
                    input logic ce, input logic [31:0] exp);
    rom_addr_i = a;
    rom_ce_i = ce;
    #1;
    chk(name, rom_data_o, exp);
    rom_ce_i = 1'b0;
  endtask

  function automatic logic [7:0] sum8(input bq_t q, input int from);
    logic [7:0] s = 8'h00;
    for (int i = from; i < q.size(); i++) s = s + q[i];
    return s;
  endfunction

  // Whole stream for a word list, including the trailing checksum when enabled
  function automatic bq_t mk_stream(input wq_t w);
    bq_t q;
    q.push_back(8'(w.size() >> 8));
    q.push_back(8'(w.size()));
    foreach (w[i]) begin
      q.push_back(w[i][31:24]);
      q.push_back(w[i][23:16]);
      q.push_back(w[i][15:8]);
      q.push_back(w[i][7:0]);
    end
`ifdef LOADER_CHECKSUM_EN
    q.push_back(sum8(q, 2));
`endif
    return q;
  endfunction

  task automatic model_write(input wq_t w);
    foreach (w[i]) begin
      exp_mem[i] = w[i];
      known[i] = 1'b1;
    end
  endtask

  task automatic read_all(input string name);
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      if (known[i]) begin
        a = (32'(i) << 2) | 32'($urandom_range(3, 0));
        a = a | ($urandom << 6);
        rd(name, a, 1'b1, exp_mem[i]);
      end
    end
  endtask

  task automatic load_words(input string name, input wq_t w, input int maxgap);
    send_q(mk_stream(w), maxgap);
    model_write(w);
    status(name, 1'b1, 1'b0);
    read_all(name);
  endtask

  rv_t tbl [7];
  wq_t w;
  bq_t q;

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    tbl[0] = '{32'h0000_0004, 1'b1, 32'h0000_0000};
    tbl[1] = '{32'h0000_0000, 1'b1, 32'h3401_0001};
    tbl[2] = '{32'h0000_0000, 1'b0, 32'h0000_0000};
    tbl[3] = '{32'h0000_0003, 1'b1, 32'h3401_0001};
    tbl[4] = '{32'h0000_0040, 1'b1, 32'h3401_0001};
    tbl[5] = '{32'h0000_0044, 1'b1, 32'h0000_0000};
    tbl[6] = '{32'hFFFF_FFC0, 1'b1, 32'h3401_0001};

    // reset values
    #12;
    status("reset", 1'b0, 1'b0);
    rd("reset_rd", 32'h0, 1'b1, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();

    // two-word load; done must not rise before the final byte
    w = '{32'h3401_0001, 32'h0000_0000};
    q = mk_stream(w);
    for (int i = 0; i < q.size() - 1; i++) send(q[i], 0);
    status("t1_pre", 1'b0, 1'b0);
    send(q[q.size()-1], 0);
    model_write(w);
    status("t1_done", 1'b1, 1'b0);
    foreach (tbl[i])
      rd($sformatf("t1_tbl%0d", i), tbl[i].addr, tbl[i].ce, tbl[i].data);

    // re-arm, then an empty load; memory must survive
    pulse_start();
    status("t2_rearm", 1'b0, 1'b0);
    rd("t2_rd_busy", 32'h0, 1'b1, 32'h0);
    send(8'h00, 0);
    send(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    status("t2_csum_wait", 1'b0, 1'b0);
    send(8'h00, 0);
`endif
    status("t2_done", 1'b1, 1'b0);
    rd("t2_keep", 32'h0, 1'b1, 32'h3401_0001);

    // count 17 exceeds depth 16; start mid-count is ignored
    pulse_start();
    send(8'h00, 0);
    pulse_start();
    send(8'h11, 0);
    status("t3_err", 1'b0, 1'b1);
    send(8'h00, 0);
    status("t3_ignored", 1'b0, 1'b1);
    pulse_start();
    status("t3_clear", 1'b0, 1'b0);

    // five-cycle gap inside a word
    q = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send(q[0], 0);
    send(q[1], 0);
    send(q[2], 0);
    send(q[3], 0);
    repeat (5) tick();
    status("t4_gap", 1'b0, 1'b0);
    send(q[4], 0);
    send(q[5], 0);
`ifdef LOADER_CHECKSUM_EN
    send(sum8(q, 2), 0);
`endif
    w = '{32'hAABB_CCDD};
    model_write(w);
    status("t4_done", 1'b1, 1'b0);
    rd("t4_alias", 32'h0000_0040, 1'b1, 32'hAABB_CCDD);

    // asynchronous reset mid-word, then full reload
    pulse_start();
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    Rst_n = 1'b0;
    #2;
    status("t5_async", 1'b0, 1'b0);
    tick();
    tick();
    Rst_n = 1'b1;
    tick();
    status("t5_after", 1'b0, 1'b0);
    w = '{32'hDEAD_BEEF};
    load_words("t5_reload", w, 0);
    rd("t5_word1", 32'h4, 1'b1, 32'h0);

`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    send_q('{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A}, 0);
    exp_mem[0] = 32'h0102_0304;
    status("t6_good", 1'b1, 1'b0);
    rd("t6_rd", 32'h0, 1'b1, 32'h0102_0304);
    pulse_start();
    send_q('{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B}, 0);
    status("t6_bad", 1'b0, 1'b1);
    pulse_start();
`else
    pulse_start();
`endif

    // exactly DEPTH words is legal
    w = {};
    for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
    load_words("full", w, 1);

    // random loads, some with over-depth counts
    for (int it = 0; it < 12; it++) begin
      int n;
      pulse_start();
      if ($urandom_range(3, 0) == 0) begin
        n = $urandom_range(65535, DEPTH + 1);
        send(8'(n >> 8), $urandom_range(2, 0));
        send(8'(n), $urandom_range(2, 0));
        status($sformatf("rnd%0d_err", it), 1'b0, 1'b1);
      end else begin
        n = $urandom_range(DEPTH, 0);
        w = {};
        for (int i = 0; i < n; i++) w.push_back($urandom);
        load_words($sformatf("rnd%0d", it), w, 3);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
